// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared types and helpers for the writeback (CDB) arbiter.
//   wb_src_e  : source index encoding on cdb_src (WB_NONE when nothing is broadcast)
//   NSRC      : number of functional-unit sources sharing the CDB
//   rob_age() : distance of a ROB tag from the ROB head, wrapping at 2**w
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_B    = 2'd1,
    WB_MEM  = 2'd2,
    WB_NONE = 2'd3
  } wb_src_e;

  localparam int NSRC = 3;

  // Unsigned wrap subtract; the result is confined to the low w bits so a
  // tag just past the wrap point still reads as younger than the head.
  function automatic logic [31:0] rob_age(input logic [31:0] tag,
                                          input logic [31:0] head,
                                          input int          w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (tag - head) & mask;
  endfunction

endpackage

// File: rtl/wb_src_queue.sv
// wb_src_queue: per-source result FIFO with age-based squash and compaction.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset (empties the queue)
//   push, push_pd/tag/data  enqueue one result at the clock edge
//   pop                     head was granted onto the CDB; drop it at the edge
//   flush, flush_age        squash every entry whose age exceeds flush_age
//   rob_head                age reference
//   ready                   queue can take a result this cycle (never pop-through)
//   empty                   no entry held
//   head_pd/tag/data        oldest entry of this queue
module wb_src_queue
  import wb_arbiter_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int PREG_W = 7,
  parameter int ROB_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [PREG_W-1:0] push_pd,
  input  logic [ROB_W-1:0]  push_tag,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  input  logic [ROB_W-1:0]  flush_age,
  input  logic [ROB_W-1:0]  rob_head,
  output logic              ready,
  output logic              empty,
  output logic [PREG_W-1:0] head_pd,
  output logic [ROB_W-1:0]  head_tag,
  output logic [DATA_W-1:0] head_data
);

  localparam int CW = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [PREG_W-1:0] pd;
    logic [ROB_W-1:0]  rob_tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t         mem   [QDEPTH];
  entry_t         mem_n [QDEPTH];
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_n;
  logic [QDEPTH-1:0] keep;
  int             fill;

  assign ready     = reset_n && (count < CW'(QDEPTH));
  assign empty     = (count == '0);
  assign head_pd   = mem[0].pd;
  assign head_tag  = mem[0].rob_tag;
  assign head_data = mem[0].data;

  // Survivors (not popped, not squashed) slide down in order, then the new
  // result is appended behind them.
  always_comb begin
    mem_n = mem;
    keep  = '0;
    fill  = 0;
    for (int i = 0; i < QDEPTH; i++) begin
      keep[i] = (CW'(i) < count) && !(pop && (i == 0)) &&
                !(flush && (ROB_W'(rob_age(32'(mem[i].rob_tag), 32'(rob_head), ROB_W)) > flush_age));
      if (keep[i]) begin
        mem_n[fill] = mem[i];
        fill        = fill + 1;
      end
    end
    if (push && (fill < QDEPTH)) begin
      mem_n[fill] = '{pd: push_pd, rob_tag: push_tag, data: push_data};
      fill        = fill + 1;
    end
    count_n = CW'(fill);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count <= '0;
    else          count <= count_n;
  end

  always_ff @(posedge clk) begin
    mem <= mem_n;
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: oldest-first arbitration of ALU/branch/memory results onto the
// single completion bus (CDB), with mispredict squash and a conflict counter.
// Optional feature macro: WB_ARB_BYPASS_EN -- an empty queue with a valid
// input offers that input as a candidate in the same cycle (0-cycle latency);
// a bypassed result is never enqueued.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   src_valid/src_ready [3]           per-source handshake ([0]=ALU [1]=B [2]=MEM)
//   src_pd/src_rob_tag/src_data       per-source result fields, packed by index
//   rob_head                          age reference
//   mispredict, mispredict_tag        flush pulse and the mispredicted branch tag
//   cdb_valid/pd/rob_tag/data/src     broadcast (fields 0 and src=3 when idle)
//   conflict_cnt                      saturating count of contended cycles
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int PREG_W = 7,
  parameter int ROB_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NSRC-1:0]        src_valid,
  output logic [NSRC-1:0]        src_ready,
  input  logic [NSRC*PREG_W-1:0] src_pd,
  input  logic [NSRC*ROB_W-1:0]  src_rob_tag,
  input  logic [NSRC*DATA_W-1:0] src_data,
  input  logic [ROB_W-1:0]       rob_head,
  input  logic                   mispredict,
  input  logic [ROB_W-1:0]       mispredict_tag,
  output logic                   cdb_valid,
  output logic [PREG_W-1:0]      cdb_pd,
  output logic [ROB_W-1:0]       cdb_rob_tag,
  output logic [DATA_W-1:0]      cdb_data,
  output logic [1:0]             cdb_src,
  output logic [15:0]            conflict_cnt
);

  typedef struct packed {
    logic [PREG_W-1:0] pd;
    logic [ROB_W-1:0]  rob_tag;
    logic [DATA_W-1:0] data;
  } cdb_data_t;

  logic [ROB_W-1:0]  flush_age;
  logic [NSRC-1:0]   q_empty, push, pop, cand_v, cand_byp, in_squash;
  logic [PREG_W-1:0] q_pd   [NSRC];
  logic [ROB_W-1:0]  q_tag  [NSRC];
  logic [DATA_W-1:0] q_data [NSRC];
  cdb_data_t         cand   [NSRC];
  logic [ROB_W-1:0]  cand_age [NSRC];
  logic              gnt_v, gnt_squash;
  logic [1:0]        gnt;
  logic [ROB_W-1:0]  best_age;
  logic [1:0]        ncand;

  assign flush_age = ROB_W'(rob_age(32'(mispredict_tag), 32'(rob_head), ROB_W));

  for (genvar g = 0; g < NSRC; g++) begin : g_q
    wb_src_queue #(
      .QDEPTH (QDEPTH),
      .PREG_W (PREG_W),
      .ROB_W  (ROB_W),
      .DATA_W (DATA_W)
    ) u_q (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push[g]),
      .push_pd   (src_pd[g*PREG_W +: PREG_W]),
      .push_tag  (src_rob_tag[g*ROB_W +: ROB_W]),
      .push_data (src_data[g*DATA_W +: DATA_W]),
      .pop       (pop[g]),
      .flush     (mispredict),
      .flush_age (flush_age),
      .rob_head  (rob_head),
      .ready     (src_ready[g]),
      .empty     (q_empty[g]),
      .head_pd   (q_pd[g]),
      .head_tag  (q_tag[g]),
      .head_data (q_data[g])
    );
  end

  // Candidate per source: queue head, or the live input when bypassing.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
`ifdef WB_ARB_BYPASS_EN
      cand_byp[i] = reset_n && q_empty[i] && src_valid[i];
`else
      cand_byp[i] = 1'b0;
`endif
      cand_v[i]   = !q_empty[i] || cand_byp[i];
      cand[i]     = cand_byp[i] ?
                    '{pd: src_pd[i*PREG_W +: PREG_W], rob_tag: src_rob_tag[i*ROB_W +: ROB_W],
                      data: src_data[i*DATA_W +: DATA_W]} :
                    '{pd: q_pd[i], rob_tag: q_tag[i], data: q_data[i]};
      cand_age[i] = ROB_W'(rob_age(32'(cand[i].rob_tag), 32'(rob_head), ROB_W));
      in_squash[i] = mispredict &&
                     (ROB_W'(rob_age(32'(src_rob_tag[i*ROB_W +: ROB_W]), 32'(rob_head), ROB_W)) > flush_age);
    end
  end

  // Oldest-first select; strict '<' keeps the lowest index on a tie.
  always_comb begin
    gnt_v    = 1'b0;
    gnt      = 2'd0;
    best_age = '0;
    ncand    = 2'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (cand_v[i]) begin
        ncand = ncand + 2'd1;
        if (!gnt_v || (cand_age[i] < best_age)) begin
          gnt_v    = 1'b1;
          gnt      = 2'(i);
          best_age = cand_age[i];
        end
      end
    end
    gnt_squash = mispredict && (best_age > flush_age);
  end

  always_comb begin
    cdb_valid   = gnt_v && !gnt_squash;
    cdb_pd      = '0;
    cdb_rob_tag = '0;
    cdb_data    = '0;
    cdb_src     = WB_NONE;
    if (cdb_valid) begin
      cdb_pd      = cand[gnt].pd;
      cdb_rob_tag = cand[gnt].rob_tag;
      cdb_data    = cand[gnt].data;
      cdb_src     = gnt;
    end
  end

  // A granted head pops even when squashed (the squash removes it anyway);
  // a granted bypass input is consumed without entering its queue.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      pop[i]  = gnt_v && (gnt == 2'(i)) && !cand_byp[i];
      push[i] = src_valid[i] && src_ready[i] && !in_squash[i] &&
                !(gnt_v && (gnt == 2'(i)) && cand_byp[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_cnt <= '0;
    end else if ((ncand >= 2'd2) && !mispredict && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scoreboard bench for wb_arbiter (default or
// WB_ARB_BYPASS_EN build). Expected broadcasts are queued when stimulus is
// driven and checked in order whenever cdb_valid is seen on a falling edge.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int QDEPTH = 2;
  localparam int PREG_W = 7;
  localparam int ROB_W  = 5;
  localparam int DATA_W = 32;
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk;
  logic                   reset_n;
  logic [2:0]             src_valid;
  logic [2:0]             src_ready;
  logic [3*PREG_W-1:0]    src_pd;
  logic [3*ROB_W-1:0]     src_rob_tag;
  logic [3*DATA_W-1:0]    src_data;
  logic [ROB_W-1:0]       rob_head;
  logic                   mispredict;
  logic [ROB_W-1:0]       mispredict_tag;
  logic                   cdb_valid;
  logic [PREG_W-1:0]      cdb_pd;
  logic [ROB_W-1:0]       cdb_rob_tag;
  logic [DATA_W-1:0]      cdb_data;
  logic [1:0]             cdb_src;
  logic [15:0]            conflict_cnt;

  wb_arbiter #(.QDEPTH(QDEPTH), .PREG_W(PREG_W), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .src_pd         (src_pd),
    .src_rob_tag    (src_rob_tag),
    .src_data       (src_data),
    .rob_head       (rob_head),
    .mispredict     (mispredict),
    .mispredict_tag (mispredict_tag),
    .cdb_valid      (cdb_valid),
    .cdb_pd         (cdb_pd),
    .cdb_rob_tag    (cdb_rob_tag),
    .cdb_data       (cdb_data),
    .cdb_src        (cdb_src),
    .conflict_cnt   (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        src;
    logic [PREG_W-1:0] pd;
    logic [ROB_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic expect_cdb(input int src, input int pd, input int tag, input logic [31:0] data);
    exp_t e;
    e.src  = 2'(src);
    e.pd   = PREG_W'(pd);
    e.tag  = ROB_W'(tag);
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic drive(input int i, input int pd, input int tag, input logic [31:0] data);
    src_valid[i]                  = 1'b1;
    src_pd[i*PREG_W +: PREG_W]    = PREG_W'(pd);
    src_rob_tag[i*ROB_W +: ROB_W] = ROB_W'(tag);
    src_data[i*DATA_W +: DATA_W]  = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (cdb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_cdb observed tag=%0d src=%0d expected no broadcast", cdb_rob_tag, cdb_src);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("cdb_src",  64'(cdb_src),     64'(e.src));
        check("cdb_pd",   64'(cdb_pd),      64'(e.pd));
        check("cdb_tag",  64'(cdb_rob_tag), 64'(e.tag));
        check("cdb_data", 64'(cdb_data),    64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0;
    int          mk;
    bit          acc;
    reset_n        = 1'b0;
    src_valid      = '0;
    src_pd         = '0;
    src_rob_tag    = '0;
    src_data       = '0;
    rob_head       = '0;
    mispredict     = 1'b0;
    mispredict_tag = '0;

    // 1: reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",    64'(src_ready),    64'd0);
    check("rst_valid",    64'(cdb_valid),    64'd0);
    check("rst_src",      64'(cdb_src),      64'd3);
    check("rst_pd",       64'(cdb_pd),       64'd0);
    check("rst_conflict", 64'(conflict_cnt), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("ready_after_rst", 64'(src_ready), 64'h7);

    // 2: single ALU result
    rob_head = 5'd0;
    drive(0, 12, 3, 32'hDEAD);
    expect_cdb(0, 12, 3, 32'hDEAD);
    @(negedge clk);
    check("t2_same_cycle", 64'(cdb_valid), 64'(BYP));
    tick();
    src_valid = '0;
    @(negedge clk);
    check("t2_next_cycle", 64'(cdb_valid), 64'(!BYP));
    tick();

    // 3: three-way contention, oldest first
    c0 = int'(conflict_cnt);
    drive(0, 21, 5, 32'hA5);
    drive(1, 22, 2, 32'hB2);
    drive(2, 23, 4, 32'hC4);
    expect_cdb(1, 22, 2, 32'hB2);
    expect_cdb(2, 23, 4, 32'hC4);
    expect_cdb(0, 21, 5, 32'hA5);
    tick();
    src_valid = '0;
    repeat (3) tick();
    check("t3_conflict", 64'(int'(conflict_cnt) - c0), 64'd2);
    check("t3_drained",  64'(sb.size()), 64'd0);

    // 4: age wraps past the ROB end
    rob_head = 5'd30;
    drive(0, 31, 1,  32'h1);
    drive(2, 32, 31, 32'h2);
    expect_cdb(2, 32, 31, 32'h2);
    expect_cdb(0, 31, 1,  32'h1);
    tick();
    src_valid = '0;
    repeat (2) tick();
    check("t4_drained", 64'(sb.size()), 64'd0);

    // 5: flush squashes queued younger MEM result, keeps older ALU result
    rob_head = 5'd4;
    drive(0, 40, 6, 32'h6);
    drive(2, 41, 9, 32'h9);
    expect_cdb(0, 40, 6, 32'h6);
    tick();
    src_valid      = '0;
    mispredict     = 1'b1;
    mispredict_tag = 5'd7;
    tick();
    mispredict = 1'b0;
    @(negedge clk);
    check("t5_mem_dropped", 64'(cdb_valid), 64'd0);
    check("t5_drained",     64'(sb.size()), 64'd0);
    tick();

    // 5b: incoming younger result during flush is accepted but dropped
    mispredict     = 1'b1;
    mispredict_tag = 5'd7;
    drive(2, 42, 9, 32'h99);
    @(negedge clk);
    check("t5b_ready",    64'(src_ready[2]), 64'd1);
    check("t5b_masked",   64'(cdb_valid),    64'd0);
    tick();
    src_valid  = '0;
    mispredict = 1'b0;
    @(negedge clk);
    check("t5b_not_kept", 64'(cdb_valid),    64'd0);
    tick();

    // 6: back-pressure on MEM while older B results keep winning
    rob_head = 5'd0;
    for (int c = 0; c < 4; c++) expect_cdb(1, 50 + c, 1 + c, 32'hB0 + 32'(c));
    mk = 0;
    for (int c = 0; (c < 20) && ((c < 4) || (mk < 3)); c++) begin
      if (c < 4) drive(1, 50 + c, 1 + c, 32'hB0 + 32'(c));
      else       src_valid[1] = 1'b0;
      if (mk < 3) drive(2, 60 + mk, 20 + mk, 32'hE0 + 32'(mk));
      else        src_valid[2] = 1'b0;
      @(negedge clk);
      acc = src_ready[2];
      if (c == 2) check("t6_mem_full",  64'(src_ready[2]), 64'd0);
      if (c < 4)  check("t6_b_ready",   64'(src_ready[1]), 64'd1);
      tick();
      if ((mk < 3) && acc) begin
        expect_cdb(2, 60 + mk, 20 + mk, 32'hE0 + 32'(mk));
        mk++;
      end
    end
    src_valid = '0;
    check("t6_all_accepted", 64'(mk), 64'd3);
    for (int c = 0; (c < 10) && (sb.size() != 0); c++) tick();
    tick();
    check("t6_drained", 64'(sb.size()), 64'd0);

    // 7: reset mid-operation discards a queued result
    rob_head = 5'd0;
    drive(0, 70, 8, 32'h70);
    if (BYP) expect_cdb(0, 70, 8, 32'h70);
    tick();
    src_valid = '0;
    reset_n   = 1'b0;
    @(negedge clk);
    check("t7_valid_in_rst", 64'(cdb_valid), 64'd0);
    check("t7_src_in_rst",   64'(cdb_src),   64'd3);
    check("t7_ready_in_rst", 64'(src_ready), 64'd0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("t7_discarded",   64'(cdb_valid),    64'd0);
    check("t7_conflict",    64'(conflict_cnt), 64'd0);
    tick();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
